// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared read-arbiter types, address map and slave index constants
//
// Purpose: holds the per-slave FSM state enum, the slave index constants,
// the address map boundaries and the address decode helper used by
// read_arbiter.
// Ports: none (package).

package axi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } rd_state_e;

    localparam int SLV_ROM     = 0;
    localparam int SLV_IM      = 1;
    localparam int SLV_DM      = 2;
    localparam int SLV_WDT     = 3;
    localparam int SLV_DMA     = 4;
    localparam int SLV_DRAM    = 5;
    localparam int SLV_DEFAULT = 6;

    localparam logic [31:0] ROM_LO  = 32'h0000_0000;
    localparam logic [31:0] ROM_HI  = 32'h0000_3FFF;
    localparam logic [31:0] IM_LO   = 32'h0001_0000;
    localparam logic [31:0] IM_HI   = 32'h0001_FFFF;
    localparam logic [31:0] DM_LO   = 32'h0002_0000;
    localparam logic [31:0] DM_HI   = 32'h0002_FFFF;
    localparam logic [31:0] WDT_LO  = 32'h1001_0000;
    localparam logic [31:0] WDT_HI  = 32'h1001_03FF;
    localparam logic [31:0] DMA_LO  = 32'h1002_0000;
    localparam logic [31:0] DMA_HI  = 32'h1002_03FF;
    localparam logic [31:0] DRAM_LO = 32'h2000_0000;
    localparam logic [31:0] DRAM_HI = 32'h201F_FFFF;

    // Map a read address onto a slave index; unmapped space goes to the
    // default slave.
    function automatic int decode_slave(input logic [31:0] addr);
        if (addr >= ROM_LO && addr <= ROM_HI)        return SLV_ROM;
        else if (addr >= IM_LO && addr <= IM_HI)     return SLV_IM;
        else if (addr >= DM_LO && addr <= DM_HI)     return SLV_DM;
        else if (addr >= WDT_LO && addr <= WDT_HI)   return SLV_WDT;
        else if (addr >= DMA_LO && addr <= DMA_HI)   return SLV_DMA;
        else if (addr >= DRAM_LO && addr <= DRAM_HI) return SLV_DRAM;
        else                                         return SLV_DEFAULT;
    endfunction

endpackage

// File: rtl/slave_read_arb.sv
// rtl/slave_read_arb.sv - per-slave read grant FSM with round-robin pointer
//
// Purpose: one IDLE/ADDR/DATA FSM for a single slave. In IDLE it picks a
// round-robin winner among the eligible masters; it holds that owner
// through the address handshake and until the RLAST handshake completes.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   eligible     - masters currently allowed to be granted by this slave
//   arvalid      - ARVALID per master, extended by a zero dummy entry
//   rready       - RREADY per master, including the dummy entry
//   arready      - this slave's ARREADY
//   rvalid       - this slave's RVALID
//   rlast        - this slave's RLAST
//   sel          - registered owner index (NUM_M when idle)
//   busy         - high in ADDR/DATA

import axi_pkg::*;

module slave_read_arb #(
    parameter int NUM_M     = 3,
    parameter int SIDX_BITS = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_M-1:0]     eligible,
    input  logic [NUM_M:0]       arvalid,
    input  logic [NUM_M:0]       rready,
    input  logic                 arready,
    input  logic                 rvalid,
    input  logic                 rlast,
    output logic [SIDX_BITS-1:0] sel,
    output logic                 busy
);

    rd_state_e            state_q, state_d;
    logic [SIDX_BITS-1:0] owner_q, owner_d;
    logic [SIDX_BITS-1:0] ptr_q, ptr_d;
    logic [SIDX_BITS-1:0] cand;
    logic [SIDX_BITS-1:0] win;
    logic                 found;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= SIDX_BITS'(NUM_M);
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cand    = '0;
        win     = '0;
        found   = 1'b0;

        // Search starts at the pointer and wraps through all masters.
        for (int i = 0; i < NUM_M; i++) begin
            cand = SIDX_BITS'((int'(ptr_q) + i) % NUM_M);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d = ST_ADDR;
                    owner_d = win;
                    ptr_d   = (win == SIDX_BITS'(NUM_M - 1)) ? '0 : win + 1'b1;
                end
            end
            ST_ADDR: begin
                // A withdrawn ARVALID keeps the grant; only the handshake moves on.
                if (arvalid[owner_q] && arready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (rvalid && rready[owner_q] && rlast) begin
                    state_d = ST_IDLE;
                    owner_d = SIDX_BITS'(NUM_M);
                end
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = SIDX_BITS'(NUM_M);
            end
        endcase
    end

    // The owner register doubles as the select output, so it is
    // purely registered.
    assign sel  = owner_q;
    assign busy = (state_q != ST_IDLE);

endmodule

// File: rtl/read_arbiter.sv
// rtl/read_arbiter.sv - multi-master, multi-slave AXI read channel arbiter
//
// Purpose: decodes each master's read address, works out which masters are
// free to be granted, and runs one slave_read_arb per slave (the last one
// being the default slave). Ownership from all slaves is merged into the
// per-master select.
// Ports:
//   ACLK, ARESET - clock, synchronous active-high reset
//   ARVALID_M    - per-master read-address valid
//   ARADDR_M     - per-master read address
//   ARREADY_S    - slave ARREADY, index 0 unused, index k = slave k-1
//   RVALID_S     - slave RVALID, same indexing
//   RLAST_S      - slave RLAST, same indexing
//   RREADY_M     - master RREADY, index NUM_M is the dummy master
//   SRIdx        - per-slave selected master, NUM_M when idle
//   MRIdx        - per-master selected slave port, 0 = none, k = slave k-1

import axi_pkg::*;

module read_arbiter #(
    parameter int NUM_M     = 3,
    parameter int NUM_S     = 6,
    parameter int MIDX_BITS = 3,
    parameter int SIDX_BITS = 2
) (
    input  logic                                ACLK,
    input  logic                                ARESET,
    input  logic [NUM_M-1:0]                    ARVALID_M,
    input  logic [NUM_M-1:0][31:0]              ARADDR_M,
    input  logic [NUM_S+1:0]                    ARREADY_S,
    input  logic [NUM_S+1:0]                    RVALID_S,
    input  logic [NUM_S+1:0]                    RLAST_S,
    input  logic [NUM_M:0]                      RREADY_M,
    output logic [NUM_S:0][SIDX_BITS-1:0]       SRIdx,
    output logic [NUM_M-1:0][MIDX_BITS-1:0]     MRIdx
);

    logic [MIDX_BITS-1:0] tgt  [NUM_M];
    logic [NUM_M-1:0]     elig [NUM_S+1];
    logic [NUM_M-1:0]     owned;
    logic [NUM_S:0]       busy;
    logic [NUM_M:0]       arvalid_ext;
    logic                 unused_port0;

    // Port 0 of the slave-side vectors carries no slave.
    assign unused_port0 = ARREADY_S[0] ^ RVALID_S[0] ^ RLAST_S[0];

    assign arvalid_ext = {1'b0, ARVALID_M};

    always_comb begin
        for (int m = 0; m < NUM_M; m++) begin
            if (decode_slave(ARADDR_M[m]) < NUM_S) begin
                tgt[m] = MIDX_BITS'(decode_slave(ARADDR_M[m]));
            end else begin
                tgt[m] = MIDX_BITS'(NUM_S);
            end
        end
    end

    // Ownership comes only from registered slave state, so MRIdx has no
    // input-to-output path and a released master is free the next cycle.
    always_comb begin
        owned = '0;
        MRIdx = '0;
        for (int s = 0; s <= NUM_S; s++) begin
            for (int m = 0; m < NUM_M; m++) begin
                if (busy[s] && (SRIdx[s] == SIDX_BITS'(m))) begin
                    owned[m] = 1'b1;
                    MRIdx[m] = MIDX_BITS'(s + 1);
                end
            end
        end
    end

    always_comb begin
        for (int s = 0; s <= NUM_S; s++) begin
            for (int m = 0; m < NUM_M; m++) begin
                elig[s][m] = ARVALID_M[m] && (tgt[m] == MIDX_BITS'(s)) && !owned[m];
            end
        end
    end

    for (genvar s = 0; s <= NUM_S; s++) begin : g_slv
        slave_read_arb #(
            .NUM_M     (NUM_M),
            .SIDX_BITS (SIDX_BITS)
        ) u_arb (
            .clk      (ACLK),
            .reset    (ARESET),
            .eligible (elig[s]),
            .arvalid  (arvalid_ext),
            .rready   (RREADY_M),
            .arready  (ARREADY_S[s+1]),
            .rvalid   (RVALID_S[s+1]),
            .rlast    (RLAST_S[s+1]),
            .sel      (SRIdx[s]),
            .busy     (busy[s])
        );
    end

endmodule

// File: tb/tb_read_arbiter.sv
// tb/tb_read_arbiter.sv - directed self-checking bench for read_arbiter

module tb_read_arbiter;

    localparam int NUM_M     = 3;
    localparam int NUM_S     = 6;
    localparam int MIDX_BITS = 3;
    localparam int SIDX_BITS = 2;

    logic                            ACLK = 1'b0;
    logic                            ARESET;
    logic [NUM_M-1:0]                ARVALID_M;
    logic [NUM_M-1:0][31:0]          ARADDR_M;
    logic [NUM_S+1:0]                ARREADY_S;
    logic [NUM_S+1:0]                RVALID_S;
    logic [NUM_S+1:0]                RLAST_S;
    logic [NUM_M:0]                  RREADY_M;
    logic [NUM_S:0][SIDX_BITS-1:0]   SRIdx;
    logic [NUM_M-1:0][MIDX_BITS-1:0] MRIdx;

    int checks   = 0;
    int failures = 0;

    read_arbiter #(
        .NUM_M     (NUM_M),
        .NUM_S     (NUM_S),
        .MIDX_BITS (MIDX_BITS),
        .SIDX_BITS (SIDX_BITS)
    ) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .ARVALID_M (ARVALID_M),
        .ARADDR_M  (ARADDR_M),
        .ARREADY_S (ARREADY_S),
        .RVALID_S  (RVALID_S),
        .RLAST_S   (RLAST_S),
        .RREADY_M  (RREADY_M),
        .SRIdx     (SRIdx),
        .MRIdx     (MRIdx)
    );

    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_sr(input string tag, input int s, input int exp);
        chk($sformatf("%s_SRIdx%0d", tag, s), 32'(SRIdx[s]), 32'(exp));
    endtask

    task automatic chk_mr(input string tag, input int m, input int exp);
        chk($sformatf("%s_MRIdx%0d", tag, m), 32'(MRIdx[m]), 32'(exp));
    endtask

    task automatic chk_all_idle(input string tag);
        for (int s = 0; s <= NUM_S; s++) chk_sr(tag, s, 3);
        for (int m = 0; m < NUM_M; m++) chk_mr(tag, m, 0);
    endtask

    task automatic clear_inputs();
        ARVALID_M = '0;
        ARADDR_M  = '0;
        ARREADY_S = '0;
        RVALID_S  = '0;
        RLAST_S   = '0;
        RREADY_M  = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
    endtask

    task automatic req(input int m, input logic [31:0] addr);
        ARADDR_M[m]  = addr;
        ARVALID_M[m] = 1'b1;
    endtask

    // Completes the address handshake of master m on slave port p.
    task automatic addr_phase(input int m, input int p);
        ARREADY_S[p] = 1'b1;
        tick();
        ARVALID_M[m] = 1'b0;
        ARREADY_S[p] = 1'b0;
    endtask

    task automatic last_beat(input int m, input int p);
        RVALID_S[p] = 1'b1;
        RLAST_S[p]  = 1'b1;
        RREADY_M[m] = 1'b1;
        tick();
        RVALID_S[p] = 1'b0;
        RLAST_S[p]  = 1'b0;
        RREADY_M[m] = 1'b0;
    endtask

    initial begin
        clear_inputs();
        ARESET = 1'b1;
        tick();
        tick();
        ARESET = 1'b0;
        chk_all_idle("reset");

        // Single-beat IM read by M1.
        req(1, 32'h0001_0040);
        tick();
        chk_sr("im_grant", 1, 1);
        chk_mr("im_grant", 1, 2);
        addr_phase(1, 2);
        chk_sr("im_data", 1, 1);
        last_beat(1, 2);
        chk_sr("im_rel", 1, 3);
        chk_mr("im_rel", 1, 0);

        // Round-robin on DM.
        req(0, 32'h0002_0000);
        req(1, 32'h0002_0000);
        tick();
        chk_sr("rr1", 2, 0);
        chk_mr("rr1", 0, 3);
        chk_mr("rr1", 1, 0);
        addr_phase(0, 3);
        last_beat(0, 3);
        chk_sr("rr1_rel", 2, 3);
        chk_mr("rr1_rel", 0, 0);
        tick();
        chk_sr("rr2", 2, 1);
        chk_mr("rr2", 1, 3);
        addr_phase(1, 3);
        last_beat(1, 3);
        req(0, 32'h0002_0000);
        req(1, 32'h0002_0000);
        req(2, 32'h0002_0000);
        tick();
        chk_sr("rr3", 2, 2);
        chk_mr("rr3", 2, 3);
        addr_phase(2, 3);
        last_beat(2, 3);
        tick();
        chk_sr("rr4", 2, 0);
        chk_mr("rr4", 0, 3);
        do_reset();

        // Independent slaves granting in the same cycle.
        req(0, 32'h0000_0100);
        req(2, 32'h2000_0100);
        tick();
        chk_sr("par", 0, 0);
        chk_sr("par", 5, 2);
        chk_mr("par", 0, 1);
        chk_mr("par", 2, 6);
        do_reset();

        // Default slave, and grant kept when ARVALID drops in ADDR.
        req(1, 32'h3000_0000);
        tick();
        chk_sr("dflt", 6, 1);
        chk_mr("dflt", 1, 7);
        ARVALID_M[1] = 1'b0;
        tick();
        chk_sr("dflt_hold", 6, 1);
        chk_mr("dflt_hold", 1, 7);
        do_reset();

        // Address map boundaries.
        req(0, 32'h0000_3FFF);
        req(2, 32'h0000_4000);
        req(1, 32'h1002_03FF);
        tick();
        chk_sr("bnd", 0, 0);
        chk_sr("bnd", 6, 2);
        chk_sr("bnd", 4, 1);
        chk_mr("bnd", 1, 5);
        chk_mr("bnd", 2, 7);
        do_reset();

        // Reset in the middle of a DRAM burst.
        req(1, 32'h2000_0000);
        tick();
        chk_sr("burst", 5, 1);
        addr_phase(1, 6);
        RVALID_S[6] = 1'b1;
        RREADY_M[1] = 1'b1;
        tick();
        chk_sr("beat1", 5, 1);
        req(0, 32'h2000_0000);
        req(1, 32'h2000_0000);
        req(2, 32'h2000_0000);
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        RVALID_S[6] = 1'b0;
        RREADY_M[1] = 1'b0;
        chk_all_idle("rst_mid");
        tick();
        chk_sr("rst_ptr", 5, 0);
        chk_mr("rst_ptr", 0, 6);
        do_reset();

        // Last beat stalled by RREADY, then immediate re-request.
        req(0, 32'h1001_0000);
        tick();
        chk_sr("stall", 3, 0);
        addr_phase(0, 4);
        RVALID_S[4] = 1'b1;
        RLAST_S[4]  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_sr($sformatf("stall_w%0d", i), 3, 0);
        end
        RREADY_M[0] = 1'b1;
        req(0, 32'h1001_0000);
        tick();
        RVALID_S[4] = 1'b0;
        RLAST_S[4]  = 1'b0;
        RREADY_M[0] = 1'b0;
        chk_sr("stall_rel", 3, 3);
        chk_mr("stall_rel", 0, 0);
        tick();
        chk_sr("regrant", 3, 0);
        chk_mr("regrant", 0, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/read_arbiter.md
READ_ARBITER -- requirements
Module: read_arbiter

Interface
REQ-001 SHALL have parameters: NUM_M, default 3, number of masters; NUM_S, default 6, number of real slaves (slave index NUM_S is the default slave); MIDX_BITS, default 3, slave-select index width; SIDX_BITS, default 2, master-select index width.
REQ-002 SHALL have ports:
- ACLK  in  1  sole clock; all state on rising edge.
- ARESET  in  1  synchronous, active-high reset.
- ARVALID_M  in  NUM_M  per-master read-address valid.
- ARADDR_M  in  NUM_M x 32  per-master read address.
- ARREADY_S  in  NUM_S+2  slave ARREADY; index 0 tied 0 at top, index k = slave k-1.
- RVALID_S, RLAST_S  in  NUM_S+2  slave R valid/last, same indexing as ARREADY_S.
- RREADY_M  in  NUM_M+1  master RREADY; index NUM_M is the dummy master, tied 0.
- SRIdx  out  (NUM_S+1) x SIDX_BITS  per-slave selected master; value NUM_M = dummy (idle).
- MRIdx  out  NUM_M x MIDX_BITS  per-master selected slave port; 0 = none, k = slave k-1.

Function
REQ-003 SHALL decode each ARADDR_M combinationally: ROM 0x0000_0000-0x0000_3FFF, IM 0x0001_0000-0x0001_FFFF, DM 0x0002_0000-0x0002_FFFF, WDT 0x1001_0000-0x1001_03FF, DMA 0x1002_0000-0x1002_03FF, DRAM 0x2000_0000-0x201F_FFFF; all other addresses select the default slave (index NUM_S).
REQ-004 SHALL keep one FSM per slave with states IDLE, ADDR, DATA.
REQ-005 IDLE: eligible masters are those with ARVALID_M=1, decode = this slave, and not owned by any slave; if any are eligible, SHALL register the round-robin winner and go to ADDR next cycle; else stay IDLE.
REQ-006 ADDR: SHALL go to DATA when ARVALID_M[owner] and ARREADY_S[s+1] are both 1; a dropped ARVALID SHALL NOT release the grant.
REQ-007 DATA: SHALL go to IDLE in the cycle after RVALID_S[s+1], RREADY_M[owner] and RLAST_S[s+1] are all 1; non-last beats keep DATA.
REQ-008 SRIdx[s] SHALL equal the owner in ADDR/DATA and NUM_M in IDLE, driven directly from registers (no combinational input-to-output path).
REQ-009 MRIdx[m] SHALL be s+1 while slave s owns master m in ADDR/DATA, else 0; a master SHALL be owned by at most one slave.
REQ-010 Grant latency: request visible in cycle N SHALL appear on SRIdx/MRIdx at cycle N+1.
REQ-011 Round-robin: each slave keeps a pointer; on grant the pointer SHALL become (winner+1) mod NUM_M; search starts at the pointer.
REQ-012 A master released by RLAST in cycle N SHALL be eligible again in cycle N+1, so it can appear regranted at N+2.
REQ-013 Several slaves MAY grant different masters in the same cycle; slaves SHALL run independently.
REQ-014 A single-beat burst (RLAST on the first beat) SHALL follow the same DATA->IDLE rule.

Reset
REQ-015 When ARESET=1 at a clock edge, all FSMs SHALL go to IDLE, all RR pointers to 0, SRIdx to NUM_M and MRIdx to 0, including mid-burst; no partial transaction resumes.

Structure
REQ-016 SHALL put the address map constants, slave index constants and the IDLE/ADDR/DATA enum in shared package axi_pkg.
REQ-017 SHALL instantiate NUM_S+1 copies of sub-module slave_read_arb (one FSM and RR pointer each); read_arbiter holds decode, eligibility and ownership merge.

Verification
REQ-018 M1 reads 0x0001_0040, len 0, ARREADY at once -> SRIdx[1]=1 and MRIdx[1]=2 from cycle N+1; both return to 3/0 the cycle after the RLAST handshake.
REQ-019 M0 and M1 both read DM (0x0002_0000) in the same cycle, pointer=0 -> M0 granted first; after M0's RLAST, M1 is granted; the next contention is won by M2 if it requests, else M0.
REQ-020 M0 reads ROM and M2 reads DRAM 0x2000_0100 in the same cycle -> SRIdx[0]=0 and SRIdx[5]=2 in the same cycle, independently.
REQ-021 M1 reads 0x3000_0000 -> default slave: SRIdx[6]=1, MRIdx[1]=7.
REQ-022 ARESET during beat 2 of a 4-beat DRAM burst -> next cycle SRIdx all 3, MRIdx all 0, pointers 0.
REQ-023 RVALID held with RREADY=0 for 5 cycles on the last beat -> grant held until the handshake, released one cycle after it.
